// File: rtl/mf_trigger_ctrl.sv
// Matched-filter trigger controller: per-lane magnitude threshold, post-reset fill mask,
// single-cycle trigger pulses with holdoff, handshaked threshold updates, saturating count.
module mf_trigger_ctrl #(
  parameter int NBITS        = 12,
  parameter int NSAMPS       = 8,
  parameter int HOLDOFF_BITS = 8,
  parameter int FILL_CYCLES  = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NBITS*NSAMPS-1:0]     data_i,
  input  logic [NBITS-1:0]            thresh_i,
  input  logic                        thresh_valid_i,
  output logic                        thresh_ready_o,
  input  logic [HOLDOFF_BITS-1:0]     holdoff_i,
  input  logic                        enable_i,
  output logic                        trig_o,
  output logic [$clog2(NSAMPS)-1:0]   trig_lane_o,
  output logic [15:0]                 trig_count_o,
  output logic [1:0]                  state_o
);

  localparam int LANE_W = $clog2(NSAMPS);
  localparam int FILL_W = $clog2(FILL_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2,
    ST_DISABLED = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [FILL_W-1:0]       r_fill_cnt;
  logic [FILL_W-1:0]       w_fill_nxt;
  logic [HOLDOFF_BITS-1:0] r_hcnt;
  logic [HOLDOFF_BITS-1:0] w_hcnt_nxt;
  logic [NBITS-1:0]        r_thr;
  logic [NSAMPS-1:0]       r_hit;
  logic [NSAMPS-1:0]       w_hit;
  logic                    r_trig;
  logic [LANE_W-1:0]       r_lane;
  logic [LANE_W-1:0]       w_first_lane;
  logic [15:0]             r_count;
  logic                    w_fire;
  logic                    w_thresh_ready;

  // Magnitude in NBITS+1 bits so the most negative code is not folded back to negative.
  for (genvar i = 0; i < NSAMPS; i++) begin : g_lane
    logic [NBITS:0] w_ext;
    logic [NBITS:0] w_mag;
    assign w_ext    = {data_i[NBITS*i+NBITS-1], data_i[NBITS*i +: NBITS]};
    assign w_mag    = w_ext[NBITS] ? (~w_ext + 1'b1) : w_ext;
    assign w_hit[i] = (r_thr != '0) && (w_mag >= {1'b0, r_thr});
  end

  always_comb begin
    w_first_lane = '0;
    for (int i = NSAMPS - 1; i >= 0; i--) begin
      if (r_hit[i]) w_first_lane = LANE_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_hcnt_nxt  = r_hcnt;
    w_fire      = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_fill_nxt = r_fill_cnt - 1'b1;
        if (r_fill_cnt == FILL_W'(1)) w_state_nxt = enable_i ? ST_ARMED : ST_DISABLED;
      end
      ST_ARMED: begin
        if (!enable_i) begin
          w_state_nxt = ST_DISABLED;
        end else if (r_hit != '0) begin
          w_fire     = 1'b1;
          w_hcnt_nxt = holdoff_i;
          if (holdoff_i != '0) w_state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        w_hcnt_nxt = r_hcnt - 1'b1;
        if (!enable_i)                             w_state_nxt = ST_DISABLED;
        else if (r_hcnt == HOLDOFF_BITS'(1))       w_state_nxt = ST_ARMED;
      end
      ST_DISABLED: begin
        if (enable_i) w_state_nxt = ST_ARMED;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  assign w_thresh_ready = (r_state == ST_ARMED) || (r_state == ST_DISABLED);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= FILL_W'(FILL_CYCLES);
      r_hcnt     <= '0;
      r_thr      <= '0;
      r_hit      <= '0;
      r_trig     <= 1'b0;
      r_lane     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_hit      <= w_hit;
      r_trig     <= w_fire;
      if (w_fire) begin
        r_lane <= w_first_lane;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
      // Stage 1 sees the new threshold from the next edge; a decision this cycle keeps the old one.
      if (thresh_valid_i && w_thresh_ready) r_thr <= thresh_i;
    end
  end

  assign thresh_ready_o = w_thresh_ready;
  assign trig_o         = r_trig;
  assign trig_lane_o    = r_lane;
  assign trig_count_o   = r_count;
  assign state_o        = r_state;

endmodule

// File: tb/tb_mf_trigger_ctrl.sv
// Directed bench for mf_trigger_ctrl: expected trigger/state/lane values are queued with
// the edge at which they are due and compared when the bench reaches that edge.
module tb_mf_trigger_ctrl;
  localparam int NBITS = 12;
  localparam int NSAMPS = 8;
  localparam int HB = 8;

  logic                    aclk;
  logic                    aresetn;
  logic [NBITS*NSAMPS-1:0] data_i;
  logic [NBITS-1:0]        thresh_i;
  logic                    thresh_valid_i;
  logic                    thresh_ready_o;
  logic [HB-1:0]           holdoff_i;
  logic                    enable_i;
  logic                    trig_o;
  logic [2:0]              trig_lane_o;
  logic [15:0]             trig_count_o;
  logic [1:0]              state_o;

  mf_trigger_ctrl #(.NBITS(NBITS), .NSAMPS(NSAMPS), .HOLDOFF_BITS(HB), .FILL_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .data_i(data_i), .thresh_i(thresh_i),
    .thresh_valid_i(thresh_valid_i), .thresh_ready_o(thresh_ready_o), .holdoff_i(holdoff_i),
    .enable_i(enable_i), .trig_o(trig_o), .trig_lane_o(trig_lane_o),
    .trig_count_o(trig_count_o), .state_o(state_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int         due;
    logic       trig;
    bit         chk_state;
    logic [1:0] st;
    bit         chk_lane;
    logic [2:0] lane;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int due, input logic trig, input bit cs, input logic [1:0] st,
                      input bit cl, input logic [2:0] lane);
    exp_t e;
    e.due = due; e.trig = trig; e.chk_state = cs; e.st = st; e.chk_lane = cl; e.lane = lane;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge aclk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("trig@%0d", e.due), 32'(trig_o), 32'(e.trig));
      if (e.chk_state) chk($sformatf("state@%0d", e.due), 32'(state_o), 32'(e.st));
      if (e.chk_lane)  chk($sformatf("lane@%0d", e.due), 32'(trig_lane_o), 32'(e.lane));
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_all(input logic [NBITS-1:0] v);
    for (int i = 0; i < NSAMPS; i++) data_i[NBITS*i +: NBITS] = v;
  endtask

  task automatic set_lane(input int i, input logic [NBITS-1:0] v);
    data_i[NBITS*i +: NBITS] = v;
  endtask

  initial begin
    aresetn = 1'b0;
    data_i = '0;
    set_all(12'd1000);
    thresh_i = 12'd500;
    thresh_valid_i = 1'b1;
    holdoff_i = 8'd0;
    enable_i = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_trig", 32'(trig_o), 32'd0);
    chk("rst_count", 32'(trig_count_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ready", 32'(thresh_ready_o), 32'd0);
    chk("rst_lane", 32'(trig_lane_o), 32'd0);
    aresetn = 1'b1;
    cyc = 0;

    // Fill masking, arming, threshold load on first ARMED edge, back-to-back triggers.
    for (int d = 1; d <= 7; d++) push(d, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0);
    for (int d = 8; d <= 10; d++) push(d, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    for (int d = 11; d <= 13; d++) push(d, 1'b1, 1'b1, 2'd1, 1'b1, 3'd0);
    ticks(8);
    chk("ready_armed", 32'(thresh_ready_o), 32'd1);
    tick();
    thresh_valid_i = 1'b0;
    ticks(4);
    chk("count_t1", 32'(trig_count_o), 32'd3);

    // Holdoff 3: pulses every 4 cycles, state pattern 2,2,2,1.
    holdoff_i = 8'd3;
    for (int k = 0; k < 10; k++) begin
      push(14 + 4*k, 1'b1, 1'b1, 2'd2, 1'b1, 3'd0);
      if (k < 9) begin
        push(15 + 4*k, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
        push(16 + 4*k, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
        push(17 + 4*k, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
      end
    end
    ticks(37);
    chk("count_t2", 32'(trig_count_o), 32'd13);

    // Threshold update held through HOLDOFF, accepted with a trigger decision.
    thresh_i = 12'd1500;
    thresh_valid_i = 1'b1;
    push(51, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
    push(52, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
    push(53, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    push(54, 1'b1, 1'b1, 2'd2, 1'b1, 3'd0);
    push(55, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
    push(56, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
    for (int d = 57; d <= 62; d++) push(d, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    chk("ready_hold50", 32'(thresh_ready_o), 32'd0);
    tick();
    chk("ready_hold51", 32'(thresh_ready_o), 32'd0);
    tick();
    chk("ready_hold52", 32'(thresh_ready_o), 32'd0);
    tick();
    chk("ready_arm53", 32'(thresh_ready_o), 32'd1);
    tick();
    thresh_valid_i = 1'b0;
    ticks(8);
    chk("count_t4", 32'(trig_count_o), 32'd14);

    // Magnitude boundary at thr=2048 and lowest-lane priority.
    holdoff_i = 8'd0;
    thresh_i = 12'd2048;
    thresh_valid_i = 1'b1;
    set_all(12'd0);
    for (int d = 63; d <= 65; d++) push(d, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    push(66, 1'b1, 1'b1, 2'd1, 1'b1, 3'd5);
    for (int d = 67; d <= 71; d++) push(d, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    push(72, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2);
    push(73, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    tick();
    thresh_valid_i = 1'b0;
    tick();
    set_lane(5, 12'h800);
    tick();
    set_lane(5, 12'd0);
    ticks(2);
    set_lane(5, 12'd2047);
    tick();
    set_lane(5, 12'd0);
    ticks(2);
    chk("lane_hold", 32'(trig_lane_o), 32'd5);
    set_lane(2, 12'h800);
    set_lane(6, 12'h800);
    tick();
    set_all(12'd0);
    ticks(2);
    chk("count_t3", 32'(trig_count_o), 32'd16);

    // Enable drop on the hit cycle, then re-enable.
    set_lane(0, 12'h800);
    push(74, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    push(75, 1'b0, 1'b1, 2'd3, 1'b0, 3'd0);
    push(76, 1'b0, 1'b1, 2'd3, 1'b0, 3'd0);
    push(77, 1'b0, 1'b1, 2'd3, 1'b0, 3'd0);
    push(78, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    push(79, 1'b1, 1'b1, 2'd1, 1'b1, 3'd0);
    push(80, 1'b1, 1'b1, 2'd1, 1'b1, 3'd0);
    tick();
    enable_i = 1'b0;
    ticks(3);
    chk("ready_dis", 32'(thresh_ready_o), 32'd1);
    enable_i = 1'b1;
    ticks(3);
    chk("count_t5", 32'(trig_count_o), 32'd18);

    // Saturation, then asynchronous reset in the middle of a pulse.
    ticks(65530);
    chk("count_sat", 32'(trig_count_o), 32'hFFFF);
    chk("trig_sat", 32'(trig_o), 32'd1);
    ticks(5);
    chk("count_sat_hold", 32'(trig_count_o), 32'hFFFF);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_trig", 32'(trig_o), 32'd0);
    chk("mid_rst_count", 32'(trig_count_o), 32'd0);
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_ready", 32'(thresh_ready_o), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
